// File: rtl/mux2to1_sele.sv
// Write-back data selector for the data-memory stage.
// Picks ALU result / address or load-formatted read data for the register file,
// and also presents that value in registered form with a valid flag.
module mux2to1_sele #(
  parameter int unsigned           AWIDTH  = 32,
  parameter logic [AWIDTH-1:0]     RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] Addr,
  input  logic [AWIDTH-1:0] ReaDat,
  input  logic              MS2,
  input  logic [2:0]        LdType,
  input  logic              En,
  output logic [AWIDTH-1:0] WD,
  output logic [AWIDTH-1:0] WD_q,
  output logic              WD_vld,
  output logic              Misalign
);

  // Lane extraction below assumes at least a 32-bit word.
  if (AWIDTH < 32) begin : g_width_check
    $error("mux2to1_sele: AWIDTH must be >= 32");
  end

  localparam logic [2:0] LdLw  = 3'b000;
  localparam logic [2:0] LdLh  = 3'b001;
  localparam logic [2:0] LdLhu = 3'b010;
  localparam logic [2:0] LdLb  = 3'b011;
  localparam logic [2:0] LdLbu = 3'b100;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [AWIDTH-1:0] w_load;
  logic              w_load_mis;
  logic [AWIDTH-1:0] r_wd_q;
  logic              r_wd_vld;

  // Little-endian lane selection; Addr[0] does not affect the halfword lane.
  always_comb begin
    w_byte = ReaDat[7:0];
    unique case (Addr[1:0])
      2'b00: w_byte = ReaDat[7:0];
      2'b01: w_byte = ReaDat[15:8];
      2'b10: w_byte = ReaDat[23:16];
      2'b11: w_byte = ReaDat[31:24];
      default: w_byte = ReaDat[7:0];
    endcase
    w_half = Addr[1] ? ReaDat[31:16] : ReaDat[15:0];
  end

  // Load formatting and misalignment; unused codes 101-111 behave as LW.
  always_comb begin
    w_load     = ReaDat;
    w_load_mis = (Addr[1:0] != 2'b00);
    case (LdType)
      LdLh: begin
        w_load     = {{(AWIDTH-16){w_half[15]}}, w_half};
        w_load_mis = Addr[0];
      end
      LdLhu: begin
        w_load     = {{(AWIDTH-16){1'b0}}, w_half};
        w_load_mis = Addr[0];
      end
      LdLb: begin
        w_load     = {{(AWIDTH-8){w_byte[7]}}, w_byte};
        w_load_mis = 1'b0;
      end
      LdLbu: begin
        w_load     = {{(AWIDTH-8){1'b0}}, w_byte};
        w_load_mis = 1'b0;
      end
      LdLw: begin
        w_load     = ReaDat;
        w_load_mis = (Addr[1:0] != 2'b00);
      end
      default: begin
        w_load     = ReaDat;
        w_load_mis = (Addr[1:0] != 2'b00);
      end
    endcase
  end

  // Final select; an unknown MS2 propagates X rather than favouring a source.
  always_comb begin
    WD       = 'x;
    Misalign = 1'bx;
    case (MS2)
      1'b0: begin
        WD       = Addr;
        Misalign = 1'b0;
      end
      1'b1: begin
        WD       = w_load;
        Misalign = w_load_mis;
      end
      default: begin
        WD       = 'x;
        Misalign = 1'bx;
      end
    endcase
  end

  // Registered write-back copy; valid only for the cycle after an enabled capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_q   <= RST_VAL;
      r_wd_vld <= 1'b0;
    end else begin
      if (En) begin
        r_wd_q <= WD;
      end
      r_wd_vld <= En;
    end
  end

  assign WD_q   = r_wd_q;
  assign WD_vld = r_wd_vld;

endmodule

// File: tb/tb_mux2to1_sele.sv
// Self-checking bench for mux2to1_sele: directed vector table, register/reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_mux2to1_sele;

  logic        clk;
  logic        rst;
  logic [31:0] Addr;
  logic [31:0] ReaDat;
  logic        MS2;
  logic [2:0]  LdType;
  logic        En;
  wire  [31:0] WD;
  wire  [31:0] WD_q;
  wire         WD_vld;
  wire         Misalign;

  int n_cmp = 0;
  int n_bad = 0;

  mux2to1_sele #(
    .AWIDTH  (32),
    .RST_VAL (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Addr     (Addr),
    .ReaDat   (ReaDat),
    .MS2      (MS2),
    .LdType   (LdType),
    .En       (En),
    .WD       (WD),
    .WD_q     (WD_q),
    .WD_vld   (WD_vld),
    .Misalign (Misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: load semantics expressed with shifts, modulo and offsets.
  task automatic ref_model(input logic [31:0] a, input logic [31:0] r, input logic ms2,
                           input logic [2:0] lt, output logic [31:0] wd, output logic mis);
    longint unsigned v;
    longint unsigned av;
    longint unsigned rv;
    av = longint'(a);
    rv = longint'(r);
    if (!ms2) begin
      wd  = a;
      mis = 1'b0;
    end else begin
      case (lt)
        3'd1, 3'd2: begin
          v = (rv >> (16 * ((av / 2) % 2))) % 65536;
          if (lt == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
          mis = (av % 2) != 0;
        end
        3'd3, 3'd4: begin
          v = (rv >> (8 * (av % 4))) % 256;
          if (lt == 3'd3 && v >= 128) v = v + 64'hFFFF_FF00;
          mis = 1'b0;
        end
        default: begin
          v   = rv;
          mis = (av % 4) != 0;
        end
      endcase
      wd = v[31:0];
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] rdat;
    logic        ms2;
    logic [2:0]  lt;
    logic [31:0] exp_wd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  logic [32:0] wide_addr;
  logic [31:0] exp_wd;
  logic        exp_mis;
  logic [31:0] mdl_q;
  logic        mdl_vld;

  initial begin
    vecs.push_back('{"ones_ms0",  32'hFFFF_FFFF, 32'h0,         1'b0, 3'd0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"ones_ms1",  32'hFFFF_FFFF, 32'h0,         1'b1, 3'd0, 32'h0000_0000, 1'b1});
    vecs.push_back('{"lw_align",  32'h5555_5554, 32'h52D5_337B, 1'b1, 3'd0, 32'h52D5_337B, 1'b0});
    vecs.push_back('{"lb_l0",     32'h1000_0000, 32'h52D5_337B, 1'b1, 3'd3, 32'h0000_007B, 1'b0});
    vecs.push_back('{"lb_l2",     32'h1000_0002, 32'h52D5_337B, 1'b1, 3'd3, 32'hFFFF_FFD5, 1'b0});
    vecs.push_back('{"lbu_l2",    32'h1000_0002, 32'h52D5_337B, 1'b1, 3'd4, 32'h0000_00D5, 1'b0});
    vecs.push_back('{"lb_l3",     32'h1000_0003, 32'h52D5_337B, 1'b1, 3'd3, 32'h0000_0052, 1'b0});
    vecs.push_back('{"lbu_l1",    32'h1000_0001, 32'h52D5_337B, 1'b1, 3'd4, 32'h0000_0033, 1'b0});
    vecs.push_back('{"lh_l0",     32'h1000_0000, 32'h52D5_337B, 1'b1, 3'd1, 32'h0000_337B, 1'b0});
    vecs.push_back('{"lh_l2",     32'h1000_0002, 32'h52D5_337B, 1'b1, 3'd1, 32'h0000_52D5, 1'b0});
    vecs.push_back('{"lhu_mis",   32'h1000_0001, 32'h52D5_337B, 1'b1, 3'd2, 32'h0000_337B, 1'b1});
    vecs.push_back('{"lh_neg",    32'h1000_0002, 32'h0000_8001, 1'b1, 3'd1, 32'h0000_0000, 1'b0});
    vecs.push_back('{"lh_sext",   32'h1000_0000, 32'h0000_8001, 1'b1, 3'd1, 32'hFFFF_8001, 1'b0});
    vecs.push_back('{"lw_code7",  32'h1000_0002, 32'h52D5_337B, 1'b1, 3'd7, 32'h52D5_337B, 1'b1});
    vecs.push_back('{"ms0_ignlt", 32'h1000_0003, 32'h52D5_337B, 1'b0, 3'd3, 32'h1000_0003, 1'b0});

    rst    = 1'b1;
    En     = 1'b0;
    MS2    = 1'b0;
    LdType = 3'd0;
    Addr   = 32'h0;
    ReaDat = 32'h0;
    #2;
    check("reset_wd_q", WD_q, 32'h0);
    check("reset_vld", {31'h0, WD_vld}, 32'h0);

    // Combinational table (register held in reset meanwhile).
    foreach (vecs[i]) begin
      Addr   = vecs[i].addr;
      ReaDat = vecs[i].rdat;
      MS2    = vecs[i].ms2;
      LdType = vecs[i].lt;
      #1;
      check({vecs[i].name, "_wd"}, WD, vecs[i].exp_wd);
      check({vecs[i].name, "_mis"}, {31'h0, Misalign}, {31'h0, vecs[i].exp_mis});
    end

    // Address from a wider driver truncates to the low 32 bits.
    wide_addr = 33'h1_5555_5554;
    Addr      = wide_addr[31:0];
    ReaDat    = 32'h52D5_337B;
    LdType    = 3'd0;
    MS2       = 1'b0;
    #1;
    check("trunc_ms0", WD, 32'h5555_5554);
    MS2 = 1'b1;
    #1;
    check("trunc_ms1", WD, 32'h52D5_337B);
    check("trunc_mis", {31'h0, Misalign}, 32'h0);
    check("still_reset_q", WD_q, 32'h0);

    // Register path.
    @(negedge clk);
    rst  = 1'b0;
    En   = 1'b1;
    MS2  = 1'b0;
    Addr = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    check("cap_q", WD_q, 32'h0000_ABCD);
    check("cap_vld", {31'h0, WD_vld}, 32'h1);
    En   = 1'b0;
    Addr = 32'h0000_1111;
    @(posedge clk);
    #1;
    check("hold_q", WD_q, 32'h0000_ABCD);
    check("hold_vld", {31'h0, WD_vld}, 32'h0);
    En   = 1'b1;
    Addr = 32'h0000_ABCD;
    @(posedge clk);
    #2;
    check("recap_vld", {31'h0, WD_vld}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_q", WD_q, 32'h0);
    check("async_vld", {31'h0, WD_vld}, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    Addr = 32'h0000_1234;
    @(posedge clk);
    #1;
    check("resume_q", WD_q, 32'h0000_1234);
    check("resume_vld", {31'h0, WD_vld}, 32'h1);

    // Randomized traffic with occasional mid-cycle reset pulses.
    mdl_q   = 32'h0000_1234;
    mdl_vld = 1'b1;
    for (int n = 0; n < 400; n++) begin
      Addr   = $urandom;
      ReaDat = $urandom;
      MS2    = 1'($urandom_range(0, 1));
      LdType = 3'($urandom_range(0, 7));
      En     = 1'($urandom_range(0, 1));
      #1;
      ref_model(Addr, ReaDat, MS2, LdType, exp_wd, exp_mis);
      check("rnd_wd", WD, exp_wd);
      check("rnd_mis", {31'h0, Misalign}, {31'h0, exp_mis});
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        #1;
        check("rnd_rst_q", WD_q, 32'h0);
        check("rnd_rst_vld", {31'h0, WD_vld}, 32'h0);
        rst     = 1'b0;
        mdl_q   = 32'h0;
        mdl_vld = 1'b0;
      end
      if (En) mdl_q = exp_wd;
      mdl_vld = En;
      @(posedge clk);
      #1;
      check("rnd_q", WD_q, mdl_q);
      check("rnd_vld", {31'h0, WD_vld}, {31'h0, mdl_vld});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux2to1_sele.md
Name: mux2to1_sele

Overview:
- Write-back data selector for the data-memory stage of the 32-bit processor.
- Chooses between the ALU result/memory address (Addr) and memory read data (ReaDat), controlled by MS2, to produce the register-file write data WD.
- Read data can be narrowed and extended (byte/halfword loads).
- WD is also presented in a registered form with a valid flag for the pipelined write-back path.

Parameters:
- AWIDTH, 32, datapath width of Addr, ReaDat and WD; legal values ≥ 32 (elaboration-time check).
- RST_VAL, 0, value loaded into WD_q on reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- Addr  input  AWIDTH  ALU result / memory address.
- ReaDat  input  AWIDTH  word read from data memory.
- MS2  input  1  select: 0 = Addr, 1 = ReaDat (after load formatting).
- LdType  input  3  load format: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101–111 treated as LW.
- En  input  1  capture enable for the output register.
- WD  output  AWIDTH  combinational write data.
- WD_q  output  AWIDTH  registered write data.
- WD_vld  output  1  WD_q holds data captured with En=1.
- Misalign  output  1  combinational: load access is misaligned.

Behaviour:
- Combinational path, no clock involvement:
  - MS2=0: WD = Addr exactly. LdType is ignored and Misalign = 0.
  - MS2=1: WD = formatted ReaDat.
  - MS2 unknown/X: WD is X (no priority default).
- Load formatting, little-endian lanes, lane index from Addr:
  - LW: WD = ReaDat unchanged (all AWIDTH bits).
  - LB/LBU: byte = ReaDat[8*Addr[1:0] +: 8]. LB sign-extends to AWIDTH; LBU zero-extends.
  - LH/LHU: half = ReaDat[16*Addr[1] +: 16]. Addr[0] is ignored for lane choice. LH sign-extends; LHU zero-extends.
- Misalign (only when MS2=1):
  - = 1 when LH/LHU with Addr[0]=1.
  - = 1 when LW (including codes 101–111) with Addr[1:0] ≠ 00.
  - Misaligned data is still produced per the lane rules above.
- Register path:
  - On rst=1 (asynchronous): WD_q = RST_VAL, WD_vld = 0, immediately and regardless of clk.
  - At rising clk with rst=0 and En=1: WD_q ← WD, WD_vld ← 1.
  - At rising clk with rst=0 and En=0: WD_q holds its value; WD_vld ← 0.
  - Latency: WD_q reflects inputs one clock after sampling.
  - Reset asserted mid-operation clears WD_q/WD_vld with no wait for an edge. The first capture happens at the first rising edge after rst deasserts.
- Width rules:
  - Inputs are AWIDTH bits; wider drivers are truncated by the connecting context.
  - No arithmetic is performed; the block is pure selection and extension.

Test Plan:
- Addr=32'hFFFFFFFF, ReaDat=0, LdType=LW: MS2=0 → WD=32'hFFFFFFFF, Misalign=0; MS2=1 → WD=32'h00000000, Misalign=1 (Addr[1:0]=11).
- Addr driven from a 33-bit literal truncating to 32'h55555554, ReaDat=32'h52D5337B, LW: MS2=0 → WD=32'h55555554; MS2=1 → WD=32'h52D5337B, Misalign=0.
- Byte loads, ReaDat=32'h52D5337B, MS2=1:
  - Addr[1:0]=00, LB → 32'h0000007B.
  - Addr[1:0]=10, LB → 32'hFFFFFFD5.
  - Addr[1:0]=10, LBU → 32'h000000D5.
  - Addr[1:0]=11, LB → 32'h00000052.
- Halfword loads, ReaDat=32'h52D5337B, MS2=1:
  - Addr[1:0]=00, LH → 32'h0000337B.
  - Addr[1:0]=10, LH → 32'h000052D5.
  - Addr[1:0]=01, LHU → 32'h0000337B with Misalign=1.
- Register path:
  - En=1, MS2=0, Addr=32'h0000ABCD: next rising edge gives WD_q=32'h0000ABCD, WD_vld=1.
  - En=0: next edge gives WD_q held, WD_vld=0.
- Async reset: assert rst between clock edges while WD_q=32'h0000ABCD, WD_vld=1 → WD_q=0 and WD_vld=0 immediately. Deassert → capture resumes at the next edge with En=1.
